// File: rtl/spi_master.sv
// spi_master: 8-bit LSB-first full-duplex SPI master for all CPOL/CPHA modes.
// SCLK half-period is DIV clk cycles; every output is registered.
module spi_master #(
    parameter int DIV = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] In_Data,
    input  logic       masterCPOL,
    input  logic       masterCPHA,
    input  logic       masterMISO,
    output logic       masterSCLK,
    output logic       masterMOSI,
    output logic       masterCS_,
    output logic [7:0] read_data,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        XFER,
        TRAIL,
        DONE
    } state_t;

    localparam logic [7:0] DIV_C = 8'(DIV);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] div_cnt;
    logic [7:0] tx_sr;
    logic [7:0] rx_sr;
    logic [4:0] edge_cnt;
    logic       cpha;

    logic       active;
    logic       tick;
    logic       toggle;
    logic       lead_edge;
    logic       do_sample;
    logic       do_shift;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // edge_cnt holds the number of divider ticks already issued
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = LEAD;
            LEAD:    if (tick) state_nxt = XFER;
            XFER:    if (tick && edge_cnt == 5'd15) state_nxt = TRAIL;
            TRAIL:   if (tick && edge_cnt == 5'd17) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        active = 1'b0;
        toggle = 1'b0;
        unique case (state)
            LEAD, XFER: active = 1'b1;
            TRAIL:      active = 1'b1;
            default:    active = 1'b0;
        endcase
        tick      = active && (div_cnt == DIV_C);
        toggle    = tick && (state == LEAD || state == XFER);
        lead_edge = toggle && !edge_cnt[0];
        do_sample = toggle && (lead_edge != cpha);
        // CPHA=0 already put bit0 out at start; the last trailing edge is idle
        do_shift  = toggle && (cpha ? lead_edge
                                    : (!lead_edge && edge_cnt != 5'd15));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            masterSCLK <= 1'b0;
            masterMOSI <= 1'b0;
            masterCS_  <= 1'b1;
            read_data  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            div_cnt    <= '0;
            edge_cnt   <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            cpha       <= 1'b0;
        end else begin
            done <= (state_nxt == DONE);
            if (state == IDLE) begin
                masterSCLK <= masterCPOL;
                masterCS_  <= 1'b1;
                if (start) begin
                    tx_sr     <= In_Data;
                    rx_sr     <= '0;
                    cpha      <= masterCPHA;
                    busy      <= 1'b1;
                    masterCS_ <= 1'b0;
                    div_cnt   <= '0;
                    edge_cnt  <= '0;
                    if (!masterCPHA) masterMOSI <= In_Data[0];
                end
            end
            if (active) begin
                div_cnt <= tick ? 8'd1 : div_cnt + 8'd1;
                if (tick) edge_cnt <= edge_cnt + 5'd1;
            end
            if (toggle) masterSCLK <= ~masterSCLK;
            if (do_sample) rx_sr <= {masterMISO, rx_sr[7:1]};
            if (do_shift) begin
                masterMOSI <= cpha ? tx_sr[0] : tx_sr[1];
                tx_sr      <= {1'b0, tx_sr[7:1]};
            end
            if (state == TRAIL && state_nxt == DONE) begin
                read_data <= rx_sr;
                masterCS_ <= 1'b1;
            end
            if (state == DONE) busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: slave model on a DIV=2 instance, loopback on DIV=1.
// Expected values come from the SPI protocol rules, not the RTL structure.
module tb_spi_master;

    localparam int DIV_M = 2;
    localparam int DIV_L = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       start, cpol, cpha, miso;
    logic [7:0] in_data;
    logic       m_sclk, m_mosi, m_cs, m_busy, m_done;
    logic [7:0] m_rd;

    logic       lb_start, lb_cpol, lb_cpha;
    logic [7:0] lb_in;
    logic       lb_sclk, lb_mosi, lb_cs, lb_busy, lb_done;
    logic [7:0] lb_rd;

    int errors = 0;
    int checks = 0;

    spi_master #(.DIV(DIV_M)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .In_Data(in_data),
        .masterCPOL(cpol), .masterCPHA(cpha), .masterMISO(miso),
        .masterSCLK(m_sclk), .masterMOSI(m_mosi), .masterCS_(m_cs),
        .read_data(m_rd), .busy(m_busy), .done(m_done)
    );

    spi_master #(.DIV(DIV_L)) u_lb (
        .clk(clk), .reset_n(reset_n), .start(lb_start), .In_Data(lb_in),
        .masterCPOL(lb_cpol), .masterCPHA(lb_cpha), .masterMISO(lb_mosi),
        .masterSCLK(lb_sclk), .masterMOSI(lb_mosi), .masterCS_(lb_cs),
        .read_data(lb_rd), .busy(lb_busy), .done(lb_done)
    );

    // behavioural SPI slave: loads s_tx on CS fall, LSB first
    logic [7:0] s_tx = 8'h00;
    logic [7:0] s_rx = 8'h00;
    logic [3:0] s_idx = 4'd0;
    logic       s_pol = 1'b0, s_pha = 1'b0, s_armed = 1'b1;
    always @(m_sclk, m_cs) begin
        if (m_cs) s_armed = 1'b1;
        else if (s_armed) begin
            s_armed = 1'b0;
            s_pol = cpol;
            s_pha = cpha;
            s_idx = 4'd0;
            s_rx = 8'h00;
            if (!cpha) miso = s_tx[0];
        end else if (s_idx < 8) begin
            if (!s_pha) begin
                if (m_sclk != s_pol) s_rx[s_idx[2:0]] = m_mosi;
                else begin
                    s_idx++;
                    if (s_idx < 8) miso = s_tx[s_idx[2:0]];
                end
            end else begin
                if (m_sclk != s_pol) miso = s_tx[s_idx[2:0]];
                else begin
                    s_rx[s_idx[2:0]] = m_mosi;
                    s_idx++;
                end
            end
        end
    end

    // sniffer records MOSI bits in wire order on the loopback link
    logic [7:0] sn_byte = 8'h00;
    logic [3:0] sn_idx = 4'd0;
    logic       sn_pol = 1'b0, sn_pha = 1'b0, sn_armed = 1'b1;
    always @(lb_sclk, lb_cs) begin
        if (lb_cs) sn_armed = 1'b1;
        else if (sn_armed) begin
            sn_armed = 1'b0;
            sn_pol = lb_cpol;
            sn_pha = lb_cpha;
            sn_idx = 4'd0;
            sn_byte = 8'h00;
        end else if (sn_idx < 8 && ((lb_sclk != sn_pol) != sn_pha)) begin
            sn_byte[sn_idx[2:0]] = lb_mosi;
            sn_idx++;
        end
    end

    task automatic run_main(input logic [7:0] tx, input logic [7:0] stx,
                            input logic pol, input logic pha, input int inj_at,
                            output int done_at, output int busy_cnt,
                            output int cs_cnt, output int done_cnt,
                            output logic sclk_a, output logic sclk_b);
        int cyc;
        @(negedge clk);
        cpol = pol; cpha = pha; in_data = tx; s_tx = stx;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0; done_at = -1; busy_cnt = 0; cs_cnt = 0; done_cnt = 0;
        sclk_a = 1'bx; sclk_b = 1'bx;
        while (cyc < 400) begin
            @(posedge clk);
            cyc++;
            #1;
            if (inj_at > 0 && cyc == inj_at) begin
                start = 1'b1; in_data = 8'h00; cpol = ~pol; cpha = ~pha;
            end
            if (inj_at > 0 && cyc == inj_at + 1) start = 1'b0;
            if (m_busy) busy_cnt++;
            if (!m_cs) cs_cnt++;
            if (m_done) begin
                done_cnt++;
                if (done_at < 0) done_at = cyc;
            end
            if (cyc == DIV_M) sclk_a = m_sclk;
            if (cyc == DIV_M + 1) sclk_b = m_sclk;
            if (!m_busy) break;
        end
    endtask

    task automatic run_lb(input logic [7:0] tx, input logic pol,
                          input logic pha, output int done_at);
        int cyc;
        @(negedge clk);
        lb_cpol = pol; lb_cpha = pha; lb_in = tx;
        @(negedge clk);
        lb_start = 1'b1;
        @(posedge clk);
        #1 lb_start = 1'b0;
        cyc = 0; done_at = -1;
        while (cyc < 200) begin
            @(posedge clk);
            cyc++;
            #1;
            if (lb_done && done_at < 0) done_at = cyc;
            if (!lb_busy) break;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (m_sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk got %b exp 0", m_sclk); end
        checks++;
        if (m_mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b exp 0", m_mosi); end
        checks++;
        if (m_cs !== 1'b1) begin errors++; $display("FAIL reset_cs got %b exp 1", m_cs); end
        checks++;
        if (m_rd !== 8'h00) begin errors++; $display("FAIL reset_rd got %h exp 00", m_rd); end
        checks++;
        if (m_busy !== 1'b0 || m_done !== 1'b0) begin
            errors++; $display("FAIL reset_busy_done got %b%b exp 00", m_busy, m_done);
        end
        checks++;
        if (lb_cs !== 1'b1 || lb_busy !== 1'b0) begin
            errors++; $display("FAIL reset_lb got cs=%b busy=%b exp 1 0", lb_cs, lb_busy);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (m_sclk !== 1'b1) begin errors++; $display("FAIL idle_tracks_cpol got %b exp 1", m_sclk); end
    endtask

    task automatic test_mode0_timing();
        int da, bc, cc, dc;
        logic sa, sb;
        run_main(8'h0F, 8'hAA, 1'b0, 1'b0, 0, da, bc, cc, dc, sa, sb);
        checks++;
        if (m_rd !== 8'hAA) begin errors++; $display("FAIL m0_master_rd got %h exp aa", m_rd); end
        checks++;
        if (s_rx !== 8'h0F) begin errors++; $display("FAIL m0_slave_rx got %h exp 0f", s_rx); end
        checks++;
        if (da != 1 + 18 * DIV_M) begin errors++; $display("FAIL m0_done_at got %0d exp %0d", da, 1 + 18 * DIV_M); end
        checks++;
        if (bc != 18 * DIV_M + 1) begin errors++; $display("FAIL m0_busy_len got %0d exp %0d", bc, 18 * DIV_M + 1); end
        checks++;
        if (cc != 18 * DIV_M) begin errors++; $display("FAIL m0_cs_len got %0d exp %0d", cc, 18 * DIV_M); end
        checks++;
        if (dc != 1) begin errors++; $display("FAIL m0_done_count got %0d exp 1", dc); end
        checks++;
        if (sa !== 1'b0 || sb !== 1'b1) begin
            errors++; $display("FAIL m0_first_toggle got %b%b exp 01", sa, sb);
        end
    endtask

    task automatic test_modes();
        logic [7:0] txs [3] = '{8'hD8, 8'h59, 8'h1B};
        logic [7:0] sts [3] = '{8'h6E, 8'h00, 8'hFF};
        logic       pols [3] = '{1'b0, 1'b1, 1'b1};
        logic       phas [3] = '{1'b1, 1'b0, 1'b1};
        int da, bc, cc, dc;
        logic sa, sb;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cpol = pols[i];
            @(posedge clk);
            #1;
            checks++;
            if (m_sclk !== pols[i]) begin errors++; $display("FAIL mode%0d_idle_before got %b exp %b", i + 1, m_sclk, pols[i]); end
            run_main(txs[i], sts[i], pols[i], phas[i], 0, da, bc, cc, dc, sa, sb);
            checks++;
            if (m_rd !== sts[i]) begin errors++; $display("FAIL mode%0d_master_rd got %h exp %h", i + 1, m_rd, sts[i]); end
            checks++;
            if (s_rx !== txs[i]) begin errors++; $display("FAIL mode%0d_slave_rx got %h exp %h", i + 1, s_rx, txs[i]); end
            checks++;
            if (m_sclk !== pols[i]) begin errors++; $display("FAIL mode%0d_idle_after got %b exp %b", i + 1, m_sclk, pols[i]); end
        end
    endtask

    task automatic test_loopback();
        logic [7:0] pats [3] = '{8'h01, 8'h80, 8'hA5};
        int da;
        for (int m = 0; m < 4; m++) begin
            for (int p = 0; p < 3; p++) begin
                run_lb(pats[p], m[1], m[0], da);
                checks++;
                if (lb_rd !== pats[p]) begin errors++; $display("FAIL lb_m%0d_rd got %h exp %h", m, lb_rd, pats[p]); end
                checks++;
                if (sn_byte !== pats[p]) begin errors++; $display("FAIL lb_m%0d_wire_order got %h exp %h", m, sn_byte, pats[p]); end
                checks++;
                if (da != 1 + 18 * DIV_L) begin errors++; $display("FAIL lb_m%0d_done_at got %0d exp %0d", m, da, 1 + 18 * DIV_L); end
            end
        end
    endtask

    task automatic test_random();
        int da, bc, cc, dc;
        logic sa, sb;
        logic [7:0] tx, st;
        logic pol, pha;
        for (int i = 0; i < 16; i++) begin
            tx  = 8'($urandom_range(0, 255));
            st  = 8'($urandom_range(0, 255));
            pol = 1'($urandom_range(0, 1));
            pha = 1'($urandom_range(0, 1));
            run_main(tx, st, pol, pha, 0, da, bc, cc, dc, sa, sb);
            checks++;
            if (m_rd !== st || s_rx !== tx) begin
                errors++;
                $display("FAIL rand%0d got m=%h s=%h exp m=%h s=%h", i, m_rd, s_rx, st, tx);
            end
            checks++;
            if (da != 1 + 18 * DIV_M) begin errors++; $display("FAIL rand%0d_done_at got %0d exp %0d", i, da, 1 + 18 * DIV_M); end
        end
    endtask

    task automatic test_ignore_start();
        int da, bc, cc, dc;
        logic sa, sb;
        run_main(8'hC3, 8'h5A, 1'b0, 1'b0, 10, da, bc, cc, dc, sa, sb);
        checks++;
        if (m_rd !== 8'h5A) begin errors++; $display("FAIL ign_master_rd got %h exp 5a", m_rd); end
        checks++;
        if (s_rx !== 8'hC3) begin errors++; $display("FAIL ign_slave_rx got %h exp c3", s_rx); end
        checks++;
        if (dc != 1) begin errors++; $display("FAIL ign_done_count got %0d exp 1", dc); end
        checks++;
        if (da != 1 + 18 * DIV_M) begin errors++; $display("FAIL ign_done_at got %0d exp %0d", da, 1 + 18 * DIV_M); end
    endtask

    task automatic test_reset_mid();
        int da, bc, cc, dc;
        int seen_done;
        logic sa, sb;
        seen_done = 0;
        @(negedge clk);
        cpol = 1'b0; cpha = 1'b0; in_data = 8'h77; s_tx = 8'h11;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (m_done) seen_done++;
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (m_cs !== 1'b1 || m_busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_cs_busy got %b %b exp 1 0", m_cs, m_busy);
        end
        checks++;
        if (m_rd !== 8'h00) begin errors++; $display("FAIL rstmid_rd got %h exp 00", m_rd); end
        checks++;
        if (m_sclk !== 1'b0 || m_done !== 1'b0) begin
            errors++; $display("FAIL rstmid_sclk_done got %b %b exp 0 0", m_sclk, m_done);
        end
        repeat (2) begin
            @(posedge clk);
            #1;
            if (m_done) seen_done++;
        end
        checks++;
        if (seen_done != 0) begin errors++; $display("FAIL rstmid_no_done got %0d exp 0", seen_done); end
        @(negedge clk);
        reset_n = 1'b1;
        run_main(8'h4B, 8'hE1, 1'b1, 1'b0, 0, da, bc, cc, dc, sa, sb);
        checks++;
        if (m_rd !== 8'hE1 || s_rx !== 8'h4B) begin
            errors++; $display("FAIL rstmid_after got m=%h s=%h exp m=e1 s=4b", m_rd, s_rx);
        end
        checks++;
        if (da != 1 + 18 * DIV_M || dc != 1) begin
            errors++; $display("FAIL rstmid_after_timing got at=%0d n=%0d exp %0d 1", da, dc, 1 + 18 * DIV_M);
        end
    endtask

    task automatic test_back_to_back();
        int dcnt, run, gaps, min_gap, cyc;
        logic seen_low;
        dcnt = 0; run = 0; gaps = 0; min_gap = 1000; seen_low = 1'b0; cyc = 0;
        @(negedge clk);
        cpol = 1'b0; cpha = 1'b1; in_data = 8'h3C; s_tx = 8'h96;
        @(negedge clk);
        start = 1'b1;
        while (cyc < 300) begin
            @(posedge clk);
            cyc++;
            #1;
            if (m_cs) begin
                if (seen_low) run++;
            end else begin
                if (run > 0) begin
                    gaps++;
                    if (run < min_gap) min_gap = run;
                end
                run = 0;
                seen_low = 1'b1;
            end
            if (m_done) begin
                dcnt++;
                checks++;
                if (m_rd !== 8'h96 || s_rx !== 8'h3C) begin
                    errors++; $display("FAIL b2b_%0d got m=%h s=%h exp m=96 s=3c", dcnt, m_rd, s_rx);
                end
                if (dcnt == 3) begin
                    start = 1'b0;
                    break;
                end
            end
        end
        checks++;
        if (dcnt != 3) begin errors++; $display("FAIL b2b_done_count got %0d exp 3", dcnt); end
        checks++;
        if (gaps != 2 || min_gap < 1) begin
            errors++; $display("FAIL b2b_cs_gap got gaps=%0d min=%0d exp 2 >=1", gaps, min_gap);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (m_busy !== 1'b0) begin errors++; $display("FAIL b2b_no_extra got busy=%b exp 0", m_busy); end
    endtask

    initial begin
        start = 1'b0; cpol = 1'b1; cpha = 1'b0; in_data = 8'h00; miso = 1'b0;
        lb_start = 1'b0; lb_cpol = 1'b1; lb_cpha = 1'b0; lb_in = 8'h00;
        test_reset();
        test_mode0_timing();
        test_modes();
        test_loopback();
        test_random();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
